cpu_state_sequencer: RTL and testbench



---
 rtl/cpu_state_sequencer.sv | 75 +++++++
 tb/tb_cpu_state_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_state_sequencer.sv
// cpu_state_sequencer: multi-cycle FETCH/LOAD/MEM/LOAD_DATA/EXEC sequencer with
// bus-stall handling, mul/div handshake, halt on jump-to-zero and bus timeout.
module cpu_state_sequencer #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       function_code,
    input  logic             waitrequest,
    input  logic             halt_req,
    input  logic             md_done,
    output logic [2:0]       state,
    output logic             active,
    output logic             ir_we,
    output logic             data_we,
    output logic             pc_we,
    output logic             md_start,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [2:0] {FETCH, LOAD, MEM, LOAD_DATA, EXEC, MDWAIT, HALTED} state_t;
    localparam int WW = $clog2(WAIT_LIMIT + 1);

    state_t cur, nxt;
    logic [WW-1:0] wait_cnt;
    logic md_seen, load_op, mem_op, md_op, stall, timeout;

    assign load_op = opcode >= 6'd32 && opcode <= 6'd38;
    assign mem_op  = load_op || opcode == 6'd40 || opcode == 6'd41 || opcode == 6'd43;
    assign md_op   = opcode == 6'd0 && function_code >= 6'd24 && function_code <= 6'd27;
    // Only a bus access in progress counts as a stall; non-memory MEM ignores the bus.
    assign stall   = waitrequest && (cur == FETCH || (cur == MEM && mem_op));
    assign timeout = stall && wait_cnt == WW'(WAIT_LIMIT - 1);

    assign state    = cur;
    assign ir_we    = cur == LOAD;
    assign data_we  = cur == LOAD_DATA;
    assign md_start = cur == EXEC && md_op && !md_seen;
    assign pc_we    = cur == EXEC && !(md_op && !md_seen);

    always_comb begin
        nxt = cur;
        case (cur)
            FETCH:     nxt = timeout ? HALTED : waitrequest ? FETCH : LOAD;
            LOAD:      nxt = MEM;
            MEM:       nxt = timeout ? HALTED : stall ? MEM : load_op ? LOAD_DATA : EXEC;
            LOAD_DATA: nxt = EXEC;
            EXEC:      nxt = md_start ? MDWAIT : halt_req ? HALTED : FETCH;
            MDWAIT:    nxt = md_done ? EXEC : MDWAIT;
            HALTED:    nxt = HALTED;
            default:   nxt = HALTED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur         <= FETCH;
            active      <= 1'b0;
            bus_error   <= 1'b0;
            instr_count <= '0;
            wait_cnt    <= '0;
            md_seen     <= 1'b0;
        end else begin
            cur         <= nxt;
            active      <= nxt != HALTED;
            bus_error   <= bus_error | timeout;
            instr_count <= pc_we ? instr_count + CNT_W'(1) : instr_count;
            wait_cnt    <= stall ? wait_cnt + WW'(1) : '0;
            // Remembers that this md_op already finished so EXEC retires on return.
            md_seen     <= (cur == MDWAIT && md_done) ? 1'b1 : pc_we ? 1'b0 : md_seen;
        end
    end
endmodule

// File: tb/tb_cpu_state_sequencer.sv
// tb_cpu_state_sequencer: scoreboard bench; each vector pushes the expected
// post-edge outputs, which are popped and compared after the clock edge.
module tb_cpu_state_sequencer;
    localparam logic [2:0] F = 3'd0, L = 3'd1, M = 3'd2, LD = 3'd3, X = 3'd4, W = 3'd5, H = 3'd6;

    typedef struct packed {
        logic [2:0] s;
        logic ir, dw, pc, ms, act, be;
        logic [3:0] c;
    } exp_t;
    typedef struct packed {
        logic rn, wr, md, hr;
        exp_t e;
    } vec_t;

    logic clk = 1'b0, reset, waitrequest, halt_req, md_done;
    logic [5:0] opcode, function_code;
    logic [2:0] state;
    logic active, ir_we, data_we, pc_we, md_start, bus_error;
    logic [3:0] instr_count;
    int vectors = 0, miscompares = 0;
    exp_t sb[$];
    exp_t obs, ex;

    assign obs = {state, ir_we, data_we, pc_we, md_start, active, bus_error, instr_count};

    cpu_state_sequencer #(.WAIT_LIMIT(16), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .function_code(function_code),
        .waitrequest(waitrequest), .halt_req(halt_req), .md_done(md_done),
        .state(state), .active(active), .ir_we(ir_we), .data_we(data_we),
        .pc_we(pc_we), .md_start(md_start), .bus_error(bus_error), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t vv(logic rn, wr, md, hr, logic [2:0] s,
                                logic ir, dw, pc, ms, act, be, logic [3:0] c);
        vec_t v;
        v.rn = rn; v.wr = wr; v.md = md; v.hr = hr;
        v.e = {s, ir, dw, pc, ms, act, be, c};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset = v.rn; waitrequest = v.wr; md_done = v.md; halt_req = v.hr;
        sb.push_back(v.e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        vec_t v[$];
        opcode = 6'd0; function_code = 6'd33;
        repeat (3) v.push_back(vv(0,0,0,0, F,0,0,0,0,0,0,0));
        foreach (v[i]) begin
            drive(v[i]); ex = sb.pop_front(); vectors++;
            if (obs !== ex) begin miscompares++; $display("FAIL reset[%0d]: got %h required %h", i, obs, ex); end
        end
    endtask

    task automatic test_addu;
        vec_t v[$];
        v.push_back(vv(1,0,0,0, L,1,0,0,0,1,0,0));
        v.push_back(vv(1,0,0,0, M,0,0,0,0,1,0,0));
        v.push_back(vv(1,0,0,0, X,0,0,1,0,1,0,0));
        v.push_back(vv(1,0,0,0, F,0,0,0,0,1,0,1));
        foreach (v[i]) begin
            drive(v[i]); ex = sb.pop_front(); vectors++;
            if (obs !== ex) begin miscompares++; $display("FAIL addu[%0d]: got %h required %h", i, obs, ex); end
        end
    endtask

    task automatic test_load_stall;
        vec_t v[$];
        opcode = 6'd35;
        repeat (3) v.push_back(vv(1,1,0,0, F,0,0,0,0,1,0,1));
        v.push_back(vv(1,0,0,0, L,1,0,0,0,1,0,1));
        v.push_back(vv(1,1,0,0, M,0,0,0,0,1,0,1));
        v.push_back(vv(1,1,0,0, M,0,0,0,0,1,0,1));
        v.push_back(vv(1,1,0,0, M,0,0,0,0,1,0,1));
        v.push_back(vv(1,0,0,0, LD,0,1,0,0,1,0,1));
        v.push_back(vv(1,0,0,0, X,0,0,1,0,1,0,1));
        v.push_back(vv(1,0,0,0, F,0,0,0,0,1,0,2));
        foreach (v[i]) begin
            drive(v[i]); ex = sb.pop_front(); vectors++;
            if (obs !== ex) begin miscompares++; $display("FAIL load_stall[%0d]: got %h required %h", i, obs, ex); end
        end
    endtask

    task automatic test_mdu;
        vec_t v[$];
        opcode = 6'd0; function_code = 6'd24;
        v.push_back(vv(1,0,0,0, L,1,0,0,0,1,0,2));
        v.push_back(vv(1,0,0,0, M,0,0,0,0,1,0,2));
        v.push_back(vv(1,0,0,0, X,0,0,0,1,1,0,2));
        v.push_back(vv(1,0,1,0, W,0,0,0,0,1,0,2));
        repeat (4) v.push_back(vv(1,0,0,0, W,0,0,0,0,1,0,2));
        v.push_back(vv(1,0,1,0, X,0,0,1,0,1,0,2));
        v.push_back(vv(1,0,0,0, F,0,0,0,0,1,0,3));
        foreach (v[i]) begin
            drive(v[i]); ex = sb.pop_front(); vectors++;
            if (obs !== ex) begin miscompares++; $display("FAIL mdu[%0d]: got %h required %h", i, obs, ex); end
        end
    endtask

    task automatic test_halt;
        vec_t v[$];
        opcode = 6'd0; function_code = 6'd33;
        v.push_back(vv(1,0,0,1, L,1,0,0,0,1,0,3));
        v.push_back(vv(1,1,0,1, M,0,0,0,0,1,0,3));
        v.push_back(vv(1,1,0,1, X,0,0,1,0,1,0,3));
        v.push_back(vv(1,0,0,1, H,0,0,0,0,0,0,4));
        repeat (3) v.push_back(vv(1,1,1,1, H,0,0,0,0,0,0,4));
        v.push_back(vv(0,0,0,0, F,0,0,0,0,0,0,0));
        foreach (v[i]) begin
            drive(v[i]); ex = sb.pop_front(); vectors++;
            if (obs !== ex) begin miscompares++; $display("FAIL halt[%0d]: got %h required %h", i, obs, ex); end
        end
    endtask

    task automatic test_bus_error;
        vec_t v[$];
        repeat (15) v.push_back(vv(1,1,0,0, F,0,0,0,0,1,0,0));
        v.push_back(vv(1,1,0,0, H,0,0,0,0,0,1,0));
        v.push_back(vv(1,0,0,0, H,0,0,0,0,0,1,0));
        v.push_back(vv(0,1,0,0, F,0,0,0,0,0,0,0));
        repeat (15) v.push_back(vv(1,1,0,0, F,0,0,0,0,1,0,0));
        v.push_back(vv(1,0,0,0, L,1,0,0,0,1,0,0));
        v.push_back(vv(1,0,0,0, M,0,0,0,0,1,0,0));
        v.push_back(vv(1,0,0,0, X,0,0,1,0,1,0,0));
        v.push_back(vv(1,0,0,0, F,0,0,0,0,1,0,1));
        foreach (v[i]) begin
            drive(v[i]); ex = sb.pop_front(); vectors++;
            if (obs !== ex) begin miscompares++; $display("FAIL bus_error[%0d]: got %h required %h", i, obs, ex); end
        end
    endtask

    task automatic test_reset_mid;
        vec_t v[$];
        opcode = 6'd0; function_code = 6'd24;
        v.push_back(vv(1,0,0,0, L,1,0,0,0,1,0,1));
        v.push_back(vv(1,0,0,0, M,0,0,0,0,1,0,1));
        v.push_back(vv(1,0,0,0, X,0,0,0,1,1,0,1));
        v.push_back(vv(1,0,0,0, W,0,0,0,0,1,0,1));
        v.push_back(vv(1,0,0,0, W,0,0,0,0,1,0,1));
        v.push_back(vv(0,0,1,0, F,0,0,0,0,0,0,0));
        foreach (v[i]) begin
            drive(v[i]); ex = sb.pop_front(); vectors++;
            if (obs !== ex) begin miscompares++; $display("FAIL reset_mdwait[%0d]: got %h required %h", i, obs, ex); end
        end
        v.delete();
        opcode = 6'd43;
        v.push_back(vv(1,0,0,0, L,1,0,0,0,1,0,0));
        v.push_back(vv(1,1,0,0, M,0,0,0,0,1,0,0));
        v.push_back(vv(1,1,0,0, M,0,0,0,0,1,0,0));
        v.push_back(vv(1,1,0,0, M,0,0,0,0,1,0,0));
        v.push_back(vv(0,1,0,0, F,0,0,0,0,0,0,0));
        foreach (v[i]) begin
            drive(v[i]); ex = sb.pop_front(); vectors++;
            if (obs !== ex) begin miscompares++; $display("FAIL reset_mem[%0d]: got %h required %h", i, obs, ex); end
        end
    endtask

    task automatic test_back_to_back_wrap;
        vec_t v[$];
        logic [3:0] c = 4'd0;
        opcode = 6'd0; function_code = 6'd33;
        repeat (16) begin
            v.push_back(vv(1,0,0,0, L,1,0,0,0,1,0,c));
            v.push_back(vv(1,0,0,0, M,0,0,0,0,1,0,c));
            v.push_back(vv(1,0,0,0, X,0,0,1,0,1,0,c));
            c = c + 4'd1;
            v.push_back(vv(1,0,0,0, F,0,0,0,0,1,0,c));
        end
        foreach (v[i]) begin
            drive(v[i]); ex = sb.pop_front(); vectors++;
            if (obs !== ex) begin miscompares++; $display("FAIL wrap[%0d]: got %h required %h", i, obs, ex); end
        end
    endtask

    initial begin
        test_reset;
        test_addu;
        test_load_stall;
        test_mdu;
        test_halt;
        test_bus_error;
        test_reset_mid;
        test_back_to_back_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
